// File: rtl/fabric_config_loader.sv
// -----------------------------------------------------------------------------
// fabric_config_loader
//
// Configuration writer for the eFPGA fabric wrapper. It takes a stream of
// bitstream words over a valid/ready handshake and waits for SyncWord. It then
// packs NumRows words into FrameData_o, with row 0 in the LSBs. For each frame
// it fires one FrameStrobe_o pulse. Frames go in column-major order: all frames
// of column 0 first, then column 1, and so on. After the last frame of the last
// column it raises configured_o. A later SyncWord starts a full reconfiguration.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   word_i        bitstream word (FrameBitsPerRow bits)
//   word_valid_i  word_i is valid
//   word_ready_o  loader accepts a word (IDLE, LOAD, DONE)
//   FrameData_o   assembled frame, FrameBitsPerRow*NumRows bits
//   FrameStrobe_o one-hot frame write strobe, MaxFramesPerCol*NumColumns bits
//   configured_o  every frame has been written
//   busy_o        high in LOAD, STROBE and HOLD
// -----------------------------------------------------------------------------
module fabric_config_loader #(
  parameter int                         FrameBitsPerRow = 32,
  parameter int                         MaxFramesPerCol = 20,
  parameter int                         NumColumns      = 6,
  parameter int                         NumRows         = 10,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [FrameBitsPerRow-1:0]            word_i,
  input  logic                                  word_valid_i,
  output logic                                  word_ready_o,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData_o,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe_o,
  output logic                                  configured_o,
  output logic                                  busy_o
);

  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int FrameW  = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int ColW    = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int DataW   = FrameBitsPerRow * NumRows;
  localparam int StrobeW = MaxFramesPerCol * NumColumns;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [DataW-1:0]   frame_data_q, frame_data_d;
  logic [StrobeW-1:0] frame_strobe_q, frame_strobe_d;
  logic               configured_q, configured_d;

  logic word_fire;
  int   strobe_idx;

  // Handshake and busy depend only on state. The STROBE and HOLD cycles
  // therefore backpressure the source without looking at word_valid_i.
  assign word_ready_o = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);
  assign busy_o       = (state_q == LOAD) || (state_q == STROBE) || (state_q == HOLD);
  assign word_fire    = word_valid_i && word_ready_o;

  assign FrameData_o   = frame_data_q;
  assign FrameStrobe_o = frame_strobe_q;
  assign configured_o  = configured_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d        = state_q;
    row_d          = row_q;
    frame_d        = frame_q;
    col_d          = col_q;
    frame_data_d   = frame_data_q;
    frame_strobe_d = '0;
    configured_d   = configured_q;
    strobe_idx     = int'(col_q) * MaxFramesPerCol + int'(frame_q);

    case (state_q)
      IDLE, DONE: begin
        // Non-sync words are consumed and dropped. A sync word starts a
        // (re)configuration and clears configured_o in the same step.
        if (word_fire && (word_i == SyncWord)) begin
          state_d      = LOAD;
          row_d        = '0;
          frame_d      = '0;
          col_d        = '0;
          configured_d = 1'b0;
        end
      end

      LOAD: begin
        if (word_fire) begin
          frame_data_d[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = word_i;
          if (row_q == RowW'(NumRows - 1)) begin
            row_d   = '0;
            state_d = STROBE;
            // The strobe is registered here, so it is high exactly during
            // STROBE, one cycle after the last row word is accepted.
            for (int i = 0; i < StrobeW; i++) begin
              frame_strobe_d[i] = (i == strobe_idx);
            end
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end

      STROBE: begin
        state_d = HOLD;
      end

      HOLD: begin
        // FrameData stays untouched for this cycle. This gives the fabric hold
        // time after the strobe falls.
        state_d = LOAD;
        if (frame_q == FrameW'(MaxFramesPerCol - 1)) begin
          frame_d = '0;
          if (col_q == ColW'(NumColumns - 1)) begin
            col_d        = '0;
            state_d      = DONE;
            configured_d = 1'b1;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end else begin
          frame_d = frame_q + FrameW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the frame data bank is reset together with the control state. After a
  // reset the fabric therefore sees zeros on FrameData_o, never stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers then update together from values sampled before the edge.
      state_q        <= IDLE;
      row_q          <= '0;
      frame_q        <= '0;
      col_q          <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
      configured_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      frame_q        <= frame_d;
      col_q          <= col_d;
      frame_data_q   <= frame_data_d;
      frame_strobe_q <= frame_strobe_d;
      configured_q   <= configured_d;
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// -----------------------------------------------------------------------------
// tb_fabric_config_loader
//
// Scoreboard bench for fabric_config_loader.
//  - Stimulus pushes the expected strobe index and frame data for each frame
//    just before sending that frame's words.
//  - A monitor pops an entry and compares whenever FrameStrobe_o is non-zero.
//  - Every cycle the monitor also checks that word_ready_o is low exactly
//    during STROBE and HOLD.
//  - A second, minimal instance (1 row, 1 frame, 1 column) covers the smallest
//    parameter set.
// -----------------------------------------------------------------------------
module tb_fabric_config_loader;

  localparam int          FB   = 32;
  localparam int          MF   = 20;
  localparam int          NC   = 6;
  localparam int          NR   = 10;
  localparam int          NF   = MF * NC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [FB-1:0]    word;
  logic             valid;
  logic             ready;
  logic [FB*NR-1:0] data;
  logic [NF-1:0]    strobe;
  logic             configured;
  logic             busy;

  fabric_config_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .word_i       (word),
    .word_valid_i (valid),
    .word_ready_o (ready),
    .FrameData_o  (data),
    .FrameStrobe_o(strobe),
    .configured_o (configured),
    .busy_o       (busy)
  );

  logic [31:0] word2;
  logic        valid2;
  logic        ready2;
  logic [31:0] data2;
  logic [0:0]  strobe2;
  logic        configured2;
  logic        busy2;

  fabric_config_loader #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(1),
    .NumColumns     (1),
    .NumRows        (1)
  ) dut_min (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .word_i       (word2),
    .word_valid_i (valid2),
    .word_ready_o (ready2),
    .FrameData_o  (data2),
    .FrameStrobe_o(strobe2),
    .configured_o (configured2),
    .busy_o       (busy2)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               idx;
    logic [FB*NR-1:0] data;
  } exp_t;

  exp_t sb[$];
  bit   hold_next = 1'b0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_next = 1'b0;
      end else begin
        check("ready_vs_strobe_hold", {319'd0, ready},
              {319'd0, !((strobe != '0) || hold_next)});
        if (strobe != '0) begin
          exp_t          e;
          logic [NF-1:0] oh;
          if (sb.size() == 0) begin
            check("unexpected_strobe", {200'd0, strobe}, 320'd0);
          end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check("strobe_index", {200'd0, strobe}, {200'd0, oh});
            check("frame_data", data, e.data);
          end
          hold_next = 1'b1;
        end else begin
          hold_next = 1'b0;
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a falling edge. It returns on the falling edge after the word
  // is accepted.
  task automatic send(input logic [31:0] w, input int gap);
    int budget = 20;
    word  = w;
    valid = 1'b1;
    while (!ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ready) check("accept_timeout", {319'd0, ready}, 320'd1);
    @(negedge clk);
    valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send2(input logic [31:0] w);
    int budget = 20;
    word2  = w;
    valid2 = 1'b1;
    while (!ready2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ready2) check("accept_timeout_min", {319'd0, ready2}, 320'd1);
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  // Frame k, row r carries word {k, r}. This is the stream word n = 10k + r.
  task automatic send_frame(input int k, input int maxgap);
    exp_t e;
    e.idx  = k;
    e.data = '0;
    for (int r = 0; r < NR; r++) e.data[r*32 +: 32] = {16'(k), 16'(r)};
    sb.push_back(e);
    for (int r = 0; r < NR; r++) begin
      send({16'(k), 16'(r)}, (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
    end
  endtask

  initial begin
    logic [NF-1:0] exp57;
    int            budget;

    word   = '0;
    valid  = 1'b0;
    word2  = '0;
    valid2 = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data", data, 320'd0);
    check("rst_strobe", {200'd0, strobe}, 320'd0);
    check("rst_configured", {319'd0, configured}, 320'd0);
    check("rst_busy", {319'd0, busy}, 320'd0);
    check("rst_ready", {319'd0, ready}, 320'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Bad preamble, then a continuous full load.
    send(32'h0, 0);
    send(32'hDEAD_BEEF, 0);
    check("preamble_busy", {319'd0, busy}, 320'd0);
    send(SYNC, 0);
    check("sync_busy", {319'd0, busy}, 320'd1);
    for (int k = 0; k < NF; k++) send_frame(k, 0);
    check("cfg_at_last_strobe", {319'd0, configured}, 320'd0);
    @(negedge clk);
    check("cfg_at_hold", {319'd0, configured}, 320'd0);
    @(negedge clk);
    check("cfg_two_after_strobe", {319'd0, configured}, 320'd1);
    check("done_busy", {319'd0, busy}, 320'd0);
    check("done_ready", {319'd0, ready}, 320'd1);

    // DONE discards non-sync words.
    send(32'h1234_5678, 0);
    check("done_discard_cfg", {319'd0, configured}, 320'd1);
    check("done_discard_busy", {319'd0, busy}, 320'd0);

    // Reconfiguration with random valid gaps.
    send(SYNC, 0);
    check("reconfig_cfg_falls", {319'd0, configured}, 320'd0);
    check("reconfig_busy", {319'd0, busy}, 320'd1);
    for (int k = 0; k < NF; k++) send_frame(k, 5);
    budget = 20;
    while (!configured && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reconfig_cfg_rises", {319'd0, configured}, 320'd1);
    check("sb_empty_after_reload", 320'(sb.size()), 320'd0);

    // Reset during the frame 57 strobe.
    send(SYNC, 0);
    for (int k = 0; k <= 57; k++) send_frame(k, 0);
    #1;
    exp57 = '0;
    exp57[57] = 1'b1;
    check("strobe57_before_reset", {200'd0, strobe}, {200'd0, exp57});
    rst_n = 1'b0;
    #1;
    check("async_rst_strobe", {200'd0, strobe}, 320'd0);
    check("async_rst_data", data, 320'd0);
    check("async_rst_busy", {319'd0, busy}, 320'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < NR; r++) send({16'd3, 16'(r)}, 0);
    check("post_rst_ignored_busy", {319'd0, busy}, 320'd0);
    send(SYNC, 0);
    send_frame(0, 0);
    repeat (2) @(negedge clk);
    check("post_rst_sb_empty", 320'(sb.size()), 320'd0);

    // Minimum parameter set: 1 row, 1 frame, 1 column.
    send2(32'hA5A5_0001);
    check("min_nonsync_busy", {319'd0, busy2}, 320'd0);
    send2(SYNC);
    send2(32'h1234_ABCD);
    check("min_strobe", {319'd0, strobe2}, 320'd1);
    check("min_data", {288'd0, data2}, {288'd0, 32'h1234_ABCD});
    check("min_cfg_at_strobe", {319'd0, configured2}, 320'd0);
    @(negedge clk);
    check("min_strobe_off", {319'd0, strobe2}, 320'd0);
    @(negedge clk);
    check("min_configured", {319'd0, configured2}, 320'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
